// File: rtl/fw_interface_sequencer_pkg.sv
// rtl/fw_interface_sequencer_pkg.sv - register offsets, FSM encodings and STATUS layout
// Shared by the sequencer top and its bench-visible register decode.
package fw_interface_sequencer_pkg;

  localparam logic [2:0] REG_CHAR     = 3'd0;
  localparam logic [2:0] REG_REPORT   = 3'd1;
  localparam logic [2:0] REG_WARNING  = 3'd2;
  localparam logic [2:0] REG_ERROR    = 3'd3;
  localparam logic [2:0] REG_EXPECTED = 3'd4;
  localparam logic [2:0] REG_MEASURED = 3'd5;
  localparam logic [2:0] REG_COMPARE  = 3'd6;
  localparam logic [2:0] REG_STATUS   = 3'd7;

  localparam int STATUS_BUSY_BIT = 8;
  localparam int STATUS_OVF_BIT  = 9;

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_PULSE, ST_GAP} state_e;

  // Event order matches the bit order of the internal new_* vector.
  typedef enum logic [1:0] {EV_REPORT, EV_WARNING, EV_ERROR, EV_COMPARE} event_e;

  function automatic logic [31:0] status_word(input logic ovf, input logic busy,
                                              input logic [4:0] level);
    logic [31:0] w;
    w = {27'b0, level};
    w[STATUS_BUSY_BIT] = busy;
    w[STATUS_OVF_BIT]  = ovf;
    return w;
  endfunction

endpackage

// File: rtl/fw_if_char_fifo.sv
// rtl/fw_if_char_fifo.sv - 8-bit synchronous character FIFO with level and full/empty
// A push while full is taken only when a pop frees the slot in the same cycle.
module fw_if_char_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               wr_data,
  input  logic                     pop,
  output logic [7:0]               rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    if (do_push && !do_pop)      level_d = level_q + 1'b1;
    else if (do_pop && !do_push) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wr_data;
  end

endmodule

// File: rtl/fw_interface_sequencer.sv
// rtl/fw_interface_sequencer.sv - Wishbone slave that drains FW message chars and pulses new_* events
// Optional FW_IF_AUTO_COMMIT_EN: a CHAR write of 0x0A commits a REPORT instead of being queued.
module fw_interface_sequencer
  import fw_interface_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int MAX_CHARS    = 31,
  parameter int PULSE_CYCLES = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [4:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        new_report,
  output logic        new_warning,
  output logic        new_error,
  output logic        new_compare,
  output logic [31:0] report_reg,
  output logic [31:0] warning_reg,
  output logic [31:0] error_reg,
  output logic [31:0] expected_reg,
  output logic [31:0] measured_reg,
  output logic [5:0]  index,
  output logic [7:0]  data,
  output logic        write_mem
);

  localparam int         LVL_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int         CNT_W   = $clog2(PULSE_CYCLES);
  localparam logic [5:0] MAX_IDX = 6'(MAX_CHARS);

  state_e            state_q, state_d;
  event_e            ev_q, ev_d;
  logic [5:0]        idx_q, idx_d;
  logic [LVL_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;
  logic [3:0]        new_q, new_d;
  logic [5:0]        index_q, index_d;
  logic [7:0]        data_q, data_d;
  logic              wr_q, wr_d;
  logic [31:0]       report_q, report_d, warning_q, warning_d, error_q, error_d;
  logic [31:0]       expected_q, expected_d, measured_q, measured_d;

  logic              push, pop, fifo_full, fifo_empty;
  logic [7:0]        fifo_rd;
  logic [LVL_W-1:0]  fifo_level;
  logic              req, idle, auto_nl, accept, commit;
  event_e            commit_ev;
  logic [2:0]        reg_sel;
  logic              unused_adr;

  assign reg_sel    = wb_adr_i[4:2];
  assign unused_adr = &{1'b0, wb_adr_i[1:0]};
  assign req        = wb_cyc_i && wb_stb_i && !ack_q;
  assign idle       = (state_q == ST_IDLE);
  assign pop        = (state_q == ST_DRAIN) && (n_q != '0) && !fifo_empty;

`ifdef FW_IF_AUTO_COMMIT_EN
  assign auto_nl = (wb_dat_i[7:0] == 8'h0A);
`else
  assign auto_nl = 1'b0;
`endif

  fw_if_char_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_i),
    .push    (push),
    .wr_data (wb_dat_i[7:0]),
    .pop     (pop),
    .rd_data (fifo_rd),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d = state_q;  ev_d = ev_q;  idx_d = idx_q;  n_d = n_q;  cnt_d = cnt_q;
    ovf_d = ovf_q;  new_d = new_q;  index_d = index_q;  data_d = data_q;  wr_d = 1'b0;
    report_d = report_q;  warning_d = warning_q;  error_d = error_q;
    expected_d = expected_q;  measured_d = measured_q;
    dat_d = '0;  push = 1'b0;  accept = 1'b0;  commit = 1'b0;  commit_ev = EV_REPORT;

    // Bus side: commits complete only in IDLE, CHAR pushes only when a slot exists.
    if (req && wb_we_i) begin
      case (reg_sel)
        REG_CHAR: begin
          if (auto_nl) begin
            accept = idle;
            commit = idle;
          end else begin
            accept = !fifo_full || pop;
            push   = accept;
          end
        end
        REG_REPORT:   begin accept = idle; commit = idle; if (idle) report_d = wb_dat_i; end
        REG_WARNING:  begin accept = idle; commit = idle; commit_ev = EV_WARNING;
                            if (idle) warning_d = wb_dat_i; end
        REG_ERROR:    begin accept = idle; commit = idle; commit_ev = EV_ERROR;
                            if (idle) error_d = wb_dat_i; end
        REG_COMPARE:  begin accept = idle; commit = idle; commit_ev = EV_COMPARE; end
        REG_EXPECTED: begin accept = 1'b1; expected_d = wb_dat_i; end
        REG_MEASURED: begin accept = 1'b1; measured_d = wb_dat_i; end
        default:      accept = 1'b1;
      endcase
    end else if (req) begin
      accept = 1'b1;
      case (reg_sel)
        REG_REPORT:   dat_d = report_q;
        REG_WARNING:  dat_d = warning_q;
        REG_ERROR:    dat_d = error_q;
        REG_EXPECTED: dat_d = expected_q;
        REG_MEASURED: dat_d = measured_q;
        REG_STATUS: begin
          dat_d = status_word(ovf_q, !idle, 5'(fifo_level));
          ovf_d = 1'b0;
        end
        default:      dat_d = '0;
      endcase
    end
    ack_d = accept;

    // Sequencer side runs after the bus so an overflow set wins over a STATUS clear.
    case (state_q)
      ST_IDLE: begin
        if (commit) begin
          n_d     = fifo_level;
          ev_d    = commit_ev;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (n_q == '0) begin
          state_d = ST_PULSE;
          new_d   = 4'b0001 << ev_q;
          cnt_d   = CNT_W'(PULSE_CYCLES - 1);
        end else if (pop) begin
          n_d = n_q - 1'b1;
          if (idx_q < MAX_IDX) begin
            wr_d    = 1'b1;
            data_d  = fifo_rd;
            index_d = idx_q;
            idx_d   = idx_q + 6'd1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          new_d   = '0;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= ST_IDLE;  ev_q <= EV_REPORT;  idx_q <= '0;  n_q <= '0;  cnt_q <= '0;
      ovf_q <= 1'b0;  ack_q <= 1'b0;  dat_q <= '0;  new_q <= '0;
      index_q <= '0;  data_q <= '0;  wr_q <= 1'b0;
      report_q <= '0;  warning_q <= '0;  error_q <= '0;  expected_q <= '0;  measured_q <= '0;
    end else begin
      state_q <= state_d;  ev_q <= ev_d;  idx_q <= idx_d;  n_q <= n_d;  cnt_q <= cnt_d;
      ovf_q <= ovf_d;  ack_q <= ack_d;  dat_q <= dat_d;  new_q <= new_d;
      index_q <= index_d;  data_q <= data_d;  wr_q <= wr_d;
      report_q <= report_d;  warning_q <= warning_d;  error_q <= error_d;
      expected_q <= expected_d;  measured_q <= measured_d;
    end
  end

  assign wb_ack_o     = ack_q;
  assign wb_dat_o     = dat_q;
  assign new_report   = new_q[EV_REPORT];
  assign new_warning  = new_q[EV_WARNING];
  assign new_error    = new_q[EV_ERROR];
  assign new_compare  = new_q[EV_COMPARE];
  assign report_reg   = report_q;
  assign warning_reg  = warning_q;
  assign error_reg    = error_q;
  assign expected_reg = expected_q;
  assign measured_reg = measured_q;
  assign index        = index_q;
  assign data         = data_q;
  assign write_mem    = wr_q;

endmodule

// File: tb/tb_fw_interface_sequencer.sv
// tb/tb_fw_interface_sequencer.sv - scoreboard bench for fw_interface_sequencer
// MAX_CHARS is reduced so a 16-deep FIFO can overflow a single message.
module tb_fw_interface_sequencer;

  localparam int DEPTH = 16;
  localparam int MAXC  = 12;
  localparam int PULSE = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  adr;
  logic [31:0] dat_i, dat_o;
  logic        we, stb, cyc, ack;
  logic        new_report, new_warning, new_error, new_compare;
  logic [31:0] report_reg, warning_reg, error_reg, expected_reg, measured_reg;
  logic [5:0]  index;
  logic [7:0]  data;
  logic        write_mem;

  always #5 clk = ~clk;

  fw_interface_sequencer #(.FIFO_DEPTH(DEPTH), .MAX_CHARS(MAXC), .PULSE_CYCLES(PULSE)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o),
    .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_ack_o(ack),
    .new_report(new_report), .new_warning(new_warning), .new_error(new_error),
    .new_compare(new_compare), .report_reg(report_reg), .warning_reg(warning_reg),
    .error_reg(error_reg), .expected_reg(expected_reg), .measured_reg(measured_reg),
    .index(index), .data(data), .write_mem(write_mem)
  );

  typedef struct {int kind; int a; int b;} item_t;   // kind 0=mem(idx,byte) 1=event(which,len) 2=read(data)

  item_t sb[$];
  int    chk_cnt = 0, pass_cnt = 0;
  int    onehot_err = 0;
  bit    mon_en = 1'b0;
  int    plen[4];
  int    cyc_n = 0, last_ack_cyc = 0, rise_cyc = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic void chk(input bit ok, input string name, input longint got, input longint exp);
    chk_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endfunction

  function automatic item_t mk(input int k, input int a, input int b);
    item_t t;
    t.kind = k; t.a = a; t.b = b;
    return t;
  endfunction

  function automatic longint pack(input item_t t);
    return longint'({8'(t.kind), 32'(t.a), 16'(t.b)});
  endfunction

  function automatic void observe(input item_t o);
    item_t e;
    if (sb.size() == 0) begin
      chk(1'b0, "unexpected_output", pack(o), 0);
    end else begin
      e = sb.pop_front();
      chk(o.kind == e.kind && o.a == e.a && o.b == e.b, "sb_item", pack(o), pack(e));
    end
  endfunction

  always @(negedge clk) begin
    logic [3:0] nv;
    nv = {new_compare, new_error, new_warning, new_report};
    if (mon_en) begin
      if ($countones(nv) > 1) onehot_err++;
      if (write_mem) observe(mk(0, int'(index), int'(data)));
      if (ack && !we) observe(mk(2, int'(dat_o), 0));
      if (nv[0] && plen[0] == 0) rise_cyc = cyc_n;
      for (int i = 0; i < 4; i++) begin
        if (nv[i]) plen[i]++;
        else if (plen[i] != 0) begin
          observe(mk(1, i, plen[i]));
          plen[i] = 0;
        end
      end
    end else begin
      for (int i = 0; i < 4; i++) plen[i] = 0;
    end
  end

  task automatic bus(input logic [4:0] a, input logic [31:0] d, input bit w, input int limit,
                     output int waits, output bit acked);
    adr = a; dat_i = d; we = w; cyc = 1'b1; stb = 1'b1;
    acked = 1'b0; waits = limit;
    for (int c = 0; c < limit; c++) begin
      @(posedge clk); #1;
      if (ack) begin
        acked = 1'b1; waits = c; last_ack_cyc = cyc_n;
        break;
      end
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    int w; bit ok;
    bus(a, d, 1'b1, 60, w, ok);
    chk(ok, "write_ack", ok, 1);
  endtask

  task automatic rd(input logic [4:0] a, input int exp);
    int w; bit ok;
    sb.push_back(mk(2, exp, 0));
    bus(a, 32'h0, 1'b0, 60, w, ok);
    chk(ok && w == 0, "read_nowait", w, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  w;
    bit  ok;
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_i = '0;
    idle(3);
    chk({new_report, new_warning, new_error, new_compare, write_mem, ack} == 6'b0,
        "reset_strobes", {new_report, new_warning, new_error, new_compare, write_mem, ack}, 0);
    chk({index, data, dat_o} == '0, "reset_index_data", {index, data, dat_o}, 0);
    chk((report_reg | warning_reg | error_reg | expected_reg | measured_reg) == 0, "reset_regs",
        report_reg | warning_reg | error_reg | expected_reg | measured_reg, 0);
    rst_n = 1'b1; mon_en = 1'b1;
    idle(2);
    rd(5'h1C, 32'h0);

    // "OK" then REPORT 0x1234
    sb.push_back(mk(0, 0, 8'h4F)); sb.push_back(mk(0, 1, 8'h4B)); sb.push_back(mk(1, 0, PULSE));
    wr(5'h00, 32'h4F); wr(5'h00, 32'h4B); wr(5'h04, 32'h1234);
    idle(15);
    rd(5'h04, 32'h1234);

    // Empty-FIFO REPORT: pulse begins one cycle after the ack
    sb.push_back(mk(1, 0, PULSE));
    wr(5'h04, 32'h55);
    w = last_ack_cyc;
    idle(12);
    chk(rise_cyc - w == 1, "empty_report_latency", rise_cyc - w, 1);

    // Fill the FIFO; a 17th CHAR cannot complete and is abandoned
    for (int i = 0; i < 16; i++) wr(5'h00, 32'h61 + i);
    bus(5'h00, 32'h71, 1'b1, 8, w, ok);
    chk(!ok, "char17_stalled", ok, 0);
    rd(5'h1C, 32'h10);

    // ERROR drains 16: the first MAXC reach memory, the rest set overflow
    for (int i = 0; i < MAXC; i++) sb.push_back(mk(0, i, 8'h61 + i));
    sb.push_back(mk(1, 2, PULSE));
    wr(5'h0C, 32'hDEAD);
    idle(30);
    rd(5'h1C, 32'h200);
    rd(5'h1C, 32'h0);
    rd(5'h0C, 32'hDEAD);

    // COMPARE issued while REPORT is still pulsing
    wr(5'h10, 32'h11); wr(5'h14, 32'h22);
    sb.push_back(mk(1, 0, PULSE)); sb.push_back(mk(1, 3, PULSE));
    wr(5'h04, 32'h99);
    bus(5'h18, 32'hFFFF, 1'b1, 60, w, ok);
    chk(ok, "compare_ack", ok, 1);
    chk(w >= 3 && w <= 8, "compare_waitstates", w, 5);
    idle(12);
    rd(5'h10, 32'h11); rd(5'h14, 32'h22); rd(5'h04, 32'h99);

    // Reset in the middle of a drain
    mon_en = 1'b0;
    for (int i = 0; i < 10; i++) wr(5'h00, 32'h30 + i);
    wr(5'h04, 32'hAB);
    #2 rst_n = 1'b0;
    #1;
    chk({new_report, new_warning, new_error, new_compare, write_mem, ack} == 6'b0,
        "midreset_strobes", {new_report, new_warning, new_error, new_compare, write_mem, ack}, 0);
    chk({index, data, dat_o} == '0, "midreset_index_data", {index, data, dat_o}, 0);
    chk((report_reg | expected_reg | measured_reg) == 0, "midreset_regs",
        report_reg | expected_reg | measured_reg, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(2);
    mon_en = 1'b1;
    rd(5'h1C, 32'h0);

    // Newline handling
`ifdef FW_IF_AUTO_COMMIT_EN
    sb.push_back(mk(0, 0, 8'h41)); sb.push_back(mk(1, 0, PULSE));
    wr(5'h00, 32'h41); wr(5'h00, 32'h0A);
    idle(12);
    rd(5'h04, 32'h0);
`else
    sb.push_back(mk(0, 0, 8'h41)); sb.push_back(mk(0, 1, 8'h0A)); sb.push_back(mk(1, 0, PULSE));
    wr(5'h00, 32'h41); wr(5'h00, 32'h0A); wr(5'h04, 32'h77);
    idle(12);
    rd(5'h04, 32'h77);
`endif

    idle(4);
    chk(onehot_err == 0, "new_onehot", onehot_err, 0);
    chk(sb.size() == 0, "scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
